// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: decode, register-file, forwarding and EX-side signals of the operand fetch stage.
interface operand_fetch_stage_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [4:0]        id_rn;
    logic [4:0]        id_rm;
    logic [4:0]        id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] ex_result;
    logic              mem_reg_write;
    logic [4:0]        mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [4:0]        ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_reg_write, id_mem_read, rf_data1, rf_data2,
               ex_result, mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data, flush,
        input  stall, ex_valid, ex_a, ex_b, ex_rd, ex_reg_write, ex_mem_read, stall_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_reg_write, id_mem_read, rf_data1, rf_data2,
               ex_result, mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data, flush,
        output stall, ex_valid, ex_a, ex_b, ex_rd, ex_reg_write, ex_mem_read, stall_count
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID/EX register with EX/MEM/WB forwarding, load-use stall and a saturating stall counter.
module operand_fetch_stage #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    operand_fetch_stage_if.slave bus
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ex_fwd, hazard, bubble;
    logic [DATA_W-1:0] a_res, b_res;

    // A load in EX has no data yet, so it never forwards from EX.
    assign ex_fwd = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;
    assign hazard = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != ZR) &
                    ((ex_rd_q == bus.id_rn) | (ex_rd_q == bus.id_rm));
    assign bubble = bus.flush | hazard;

    always_comb begin
        a_res = (bus.id_rn == ZR)                                 ? '0 :
                (ex_fwd && ex_rd_q == bus.id_rn)                  ? bus.ex_result :
                (bus.mem_reg_write && bus.mem_rd == bus.id_rn)    ? bus.mem_data :
                (bus.wb_reg_write && bus.wb_rd == bus.id_rn)      ? bus.wb_data : bus.rf_data1;
        b_res = (bus.id_rm == ZR)                                 ? '0 :
                (ex_fwd && ex_rd_q == bus.id_rm)                  ? bus.ex_result :
                (bus.mem_reg_write && bus.mem_rd == bus.id_rm)    ? bus.mem_data :
                (bus.wb_reg_write && bus.wb_rd == bus.id_rm)      ? bus.wb_data : bus.rf_data2;
        ex_valid_d     = ~bubble & bus.id_valid;
        ex_reg_write_d = ~bubble & bus.id_valid & bus.id_reg_write;
        ex_mem_read_d  = ~bubble & bus.id_valid & bus.id_mem_read;
        ex_a_d         = bubble ? ex_a_q : a_res;
        ex_b_d         = bubble ? ex_b_q : b_res;
        ex_rd_d        = bubble ? ex_rd_q : bus.id_rd;
        cnt_d          = (bus.stall && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q     <= 1'b0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            cnt_q          <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.stall        = hazard & ~bus.flush;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_a         = ex_a_q;
    assign bus.ex_b         = ex_b_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_reg_write = ex_reg_write_q;
    assign bus.ex_mem_read  = ex_mem_read_q;
    assign bus.stall_count  = cnt_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed and random checks of the operand fetch stage against a behavioural pipeline model.
module tb_operand_fetch_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    operand_fetch_stage_if #(.DATA_W(64), .CNT_W(32)) a ();
    operand_fetch_stage_if #(.DATA_W(64), .CNT_W(4))  s ();

    operand_fetch_stage #(.DATA_W(64), .ZERO_REG(31), .CNT_W(32)) dut  (.clk(clk), .reset_n(reset_n), .bus(a));
    operand_fetch_stage #(.DATA_W(64), .ZERO_REG(31), .CNT_W(4))  dut4 (.clk(clk), .reset_n(reset_n), .bus(s));

    assign s.id_valid      = a.id_valid;
    assign s.id_rn         = a.id_rn;
    assign s.id_rm         = a.id_rm;
    assign s.id_rd         = a.id_rd;
    assign s.id_reg_write  = a.id_reg_write;
    assign s.id_mem_read   = a.id_mem_read;
    assign s.rf_data1      = a.rf_data1;
    assign s.rf_data2      = a.rf_data2;
    assign s.ex_result     = a.ex_result;
    assign s.mem_reg_write = a.mem_reg_write;
    assign s.mem_rd        = a.mem_rd;
    assign s.mem_data      = a.mem_data;
    assign s.wb_reg_write  = a.wb_reg_write;
    assign s.wb_rd         = a.wb_rd;
    assign s.wb_data       = a.wb_data;
    assign s.flush         = a.flush;

    // Model of the instruction sitting in EX plus the two stall counters.
    logic        m_valid, m_rw, m_mr;
    logic [4:0]  m_rd;
    logic [63:0] m_a, m_b;
    longint      m_cnt, m_cnt4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pick(input logic [4:0] src, input logic [63:0] rf);
        logic        en [3];
        logic [4:0]  r  [3];
        logic [63:0] d  [3];
        en = '{m_valid && m_rw && !m_mr, a.mem_reg_write, a.wb_reg_write};
        r  = '{m_rd, a.mem_rd, a.wb_rd};
        d  = '{a.ex_result, a.mem_data, a.wb_data};
        if (src == 5'd31) return 64'd0;
        for (int k = 0; k < 3; k++) if (en[k] && r[k] == src) return d[k];
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_rd = 0; m_a = 0; m_b = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ex_valid"},     64'(a.ex_valid),     64'(m_valid));
        chk({tag, ".ex_reg_write"}, 64'(a.ex_reg_write), 64'(m_rw));
        chk({tag, ".ex_mem_read"},  64'(a.ex_mem_read),  64'(m_mr));
        chk({tag, ".ex_rd"},        64'(a.ex_rd),        64'(m_rd));
        chk({tag, ".ex_a"},         a.ex_a,              m_a);
        chk({tag, ".ex_b"},         a.ex_b,              m_b);
        chk({tag, ".stall_count"},  64'(a.stall_count),  64'(m_cnt));
        chk({tag, ".stall_count4"}, 64'(s.stall_count),  64'(m_cnt4));
    endtask

    // One clock: check the combinational stall, advance the model, check the registered state.
    task automatic step(input string tag);
        logic        hz, st;
        logic [63:0] na, nb;
        #1;
        hz = a.id_valid && m_valid && m_mr && m_rd != 5'd31 && (m_rd == a.id_rn || m_rd == a.id_rm);
        st = hz && !a.flush;
        chk({tag, ".stall"}, 64'(a.stall), 64'(st));
        na = pick(a.id_rn, a.rf_data1);
        nb = pick(a.id_rm, a.rf_data2);
        if (a.flush || hz) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
        end else begin
            m_valid = a.id_valid;
            m_rw = a.id_valid && a.id_reg_write;
            m_mr = a.id_valid && a.id_mem_read;
            m_a = na; m_b = nb; m_rd = a.id_rd;
        end
        if (st) begin
            m_cnt  = (m_cnt  == 64'hFFFF_FFFF) ? m_cnt  : m_cnt + 1;
            m_cnt4 = (m_cnt4 == 15)            ? m_cnt4 : m_cnt4 + 1;
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic quiet();
        a.id_valid = 0; a.id_rn = 0; a.id_rm = 0; a.id_rd = 0; a.id_reg_write = 0; a.id_mem_read = 0;
        a.rf_data1 = 0; a.rf_data2 = 0; a.ex_result = 0; a.mem_reg_write = 0; a.mem_rd = 0;
        a.mem_data = 0; a.wb_reg_write = 0; a.wb_rd = 0; a.wb_data = 0; a.flush = 0;
    endtask

    task automatic issue(input logic [4:0] rn, rm, rd, input logic rw, mr);
        a.id_valid = 1; a.id_rn = rn; a.id_rm = rm; a.id_rd = rd; a.id_reg_write = rw; a.id_mem_read = mr;
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    task automatic randomize_inputs();
        a.id_valid = 1'($urandom_range(0, 5) != 0);
        a.id_rn = rreg(); a.id_rm = rreg(); a.id_rd = rreg();
        a.id_reg_write = 1'($urandom); a.id_mem_read = 1'($urandom_range(0, 2) == 0);
        a.rf_data1 = {$urandom, $urandom}; a.rf_data2 = {$urandom, $urandom};
        a.ex_result = {$urandom, $urandom}; a.mem_data = {$urandom, $urandom}; a.wb_data = {$urandom, $urandom};
        a.mem_reg_write = 1'($urandom); a.mem_rd = rreg();
        a.wb_reg_write = 1'($urandom); a.wb_rd = rreg();
        a.flush = 1'($urandom_range(0, 7) == 0);
    endtask

    initial begin
        model_reset();
        randomize_inputs();
        reset_n = 0;
        #12;
        chk("rst.stall", 64'(a.stall), 64'd0);
        check_state("rst");
        @(posedge clk);
        #1;
        reset_n = 1;
        quiet();
        issue(5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
        a.rf_data1 = 64'd5; a.rf_data2 = 64'd7;
        step("basic");
        chk("basic.a5", a.ex_a, 64'd5);
        chk("basic.b7", a.ex_b, 64'd7);

        quiet(); issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step("fwd.pre");
        issue(5'd3, 5'd0, 5'd5, 1'b1, 1'b0);
        a.ex_result = 64'hAA; a.mem_reg_write = 1; a.mem_rd = 3; a.mem_data = 64'hBB;
        a.wb_reg_write = 1; a.wb_rd = 3; a.wb_data = 64'hCC; a.rf_data1 = 64'hDD;
        step("fwd.ex");
        chk("fwd.ex.AA", a.ex_a, 64'hAA);
        step("fwd.mem");
        chk("fwd.mem.BB", a.ex_a, 64'hBB);
        a.mem_reg_write = 0;
        step("fwd.wb");
        chk("fwd.wb.CC", a.ex_a, 64'hCC);

        quiet(); issue(5'd0, 5'd0, 5'd31, 1'b1, 1'b1);
        step("zr.pre");
        issue(5'd31, 5'd31, 5'd1, 1'b1, 1'b0);
        a.ex_result = 64'hFF; a.mem_reg_write = 1; a.mem_rd = 31; a.mem_data = 64'hFF;
        a.wb_reg_write = 1; a.wb_rd = 31; a.wb_data = 64'hFF; a.rf_data1 = 64'h11; a.rf_data2 = 64'h22;
        step("zr");
        chk("zr.a0", a.ex_a, 64'd0);
        chk("zr.b0", a.ex_b, 64'd0);

        quiet(); issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        step("lu.load");
        issue(5'd1, 5'd4, 5'd6, 1'b1, 1'b0);
        #1;
        chk("lu.stall1", 64'(a.stall), 64'd1);
        step("lu.bubble");
        chk("lu.bubble.valid", 64'(a.ex_valid), 64'd0);
        a.mem_reg_write = 1; a.mem_rd = 4; a.mem_data = 64'h1234;
        step("lu.fwd");
        chk("lu.b1234", a.ex_b, 64'h1234);
        chk("lu.cnt1", 64'(a.stall_count), 64'd1);

        quiet(); issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        step("fl.load");
        issue(5'd1, 5'd4, 5'd6, 1'b1, 1'b0);
        a.flush = 1;
        step("fl");
        chk("fl.valid0", 64'(a.ex_valid), 64'd0);
        chk("fl.cnt1", 64'(a.stall_count), 64'd1);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step("rand");
        end

        quiet();
        for (int i = 0; i < 20; i++) begin
            issue(5'd0, 5'd1, 5'd6, 1'b1, 1'b1);
            step("sat.load");
            issue(5'd6, 5'd1, 5'd2, 1'b1, 1'b0);
            step("sat.use");
        end
        chk("sat.cnt15", 64'(s.stall_count), 64'd15);
        issue(5'd0, 5'd1, 5'd6, 1'b1, 1'b1);
        step("mid.load");
        issue(5'd6, 5'd1, 5'd2, 1'b1, 1'b0);
        #1;
        chk("mid.stall1", 64'(a.stall), 64'd1);
        reset_n = 0;
        #1;
        model_reset();
        chk("mid.stall0", 64'(a.stall), 64'd0);
        check_state("mid");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
